// File: rtl/spi_wb_bridge.sv
// rtl/spi_wb_bridge.sv - SPI byte-stream command decoder mastering single-byte Wishbone cycles
// Optional Wishbone ack timeout is enabled by defining SPI_WB_TIMEOUT_EN.

module spi_wb_bridge #(
  parameter int ADDR_WIDTH     = 17,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_i,
  input  logic                  spi_cs_ni,
  input  logic                  spi_strobe_i,
  input  logic [DATA_WIDTH-1:0] spi_data_i,
  output logic [DATA_WIDTH-1:0] spi_data_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  output logic                  wbm_we_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  input  logic                  wbm_ack_i,
  output logic                  busy_o,
  output logic                  error_o
);

  localparam int HI_W = ADDR_WIDTH - 16;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_RD_TURN,
    S_WR_DATA,
    S_RD_DATA
  } state_t;

  state_t state_q, state_d;

  logic strb_meta, strb_sync, strb_prev, byte_valid;
  logic cs_meta, cs_sync;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] dat_q, rd_q;
  logic wr_q, inc_q, err_q, cyc_q, we_q, discard_q;
  logic accept, overrun, start, cyc_done, timeout, rd_state;

  // Strobe and chip select cross from the SCK domain; data is quasi-static and used directly.
  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      strb_meta  <= 1'b0;
      strb_sync  <= 1'b0;
      strb_prev  <= 1'b0;
      byte_valid <= 1'b0;
      cs_meta    <= 1'b1;
      cs_sync    <= 1'b1;
    end else begin
      strb_meta  <= spi_strobe_i;
      strb_sync  <= strb_meta;
      strb_prev  <= strb_sync;
      byte_valid <= strb_sync & ~strb_prev;
      cs_meta    <= spi_cs_ni;
      cs_sync    <= cs_meta;
    end
  end

`ifdef SPI_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      tmo_cnt <= '0;
    end else if (!cyc_q) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign timeout = cyc_q & ~wbm_ack_i & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign accept   = byte_valid & ~cs_sync & ~cyc_q;
  assign overrun  = byte_valid & ~cs_sync & cyc_q;
  assign cyc_done = cyc_q & (wbm_ack_i | timeout);
  assign rd_state = (state_q == S_RD_TURN) || (state_q == S_RD_DATA);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    if (cs_sync) begin
      state_d = S_CMD;
    end else if (accept) begin
      case (state_q)
        S_CMD:     state_d = S_ADDR_HI;
        S_ADDR_HI: state_d = S_ADDR_LO;
        S_ADDR_LO: begin
          if (wr_q) begin
            state_d = S_WR_DATA;
          end else begin
            start   = 1'b1;
            state_d = S_RD_TURN;
          end
        end
        S_RD_TURN: begin
          start   = 1'b1;
          state_d = S_RD_DATA;
        end
        S_WR_DATA: start = 1'b1;
        S_RD_DATA: start = 1'b1;
        default:   state_d = S_CMD;
      endcase
    end
  end

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state_q   <= S_CMD;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      inc_q     <= 1'b0;
      err_q     <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      dat_q     <= '0;
      rd_q      <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        case (state_q)
          S_CMD: begin
            wr_q                    <= spi_data_i[7];
            inc_q                   <= spi_data_i[6];
            addr_q[ADDR_WIDTH-1:16] <= HI_W'(spi_data_i[0]);
          end
          S_ADDR_HI: addr_q[15:8] <= spi_data_i[7:0];
          S_ADDR_LO: addr_q[7:0]  <= spi_data_i[7:0];
          default: ;
        endcase
      end else if (cyc_done && inc_q) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end

      // A new command byte clears the sticky error unless its reserved bits are set.
      if (accept && state_q == S_CMD) begin
        err_q <= |spi_data_i[5:1];
      end else if (overrun || timeout) begin
        err_q <= 1'b1;
      end

      if (start) begin
        cyc_q     <= 1'b1;
        we_q      <= wr_q;
        discard_q <= 1'b0;
        if (wr_q) begin
          dat_q <= spi_data_i;
        end
      end else if (cyc_done) begin
        cyc_q <= 1'b0;
        we_q  <= 1'b0;
        if (!we_q && !discard_q && !cs_sync) begin
          rd_q <= timeout ? '1 : wbm_dat_i;
        end
      end

      // Read data belonging to a transfer the host has abandoned must not reach MISO.
      if (cs_sync) begin
        discard_q <= 1'b1;
      end
    end
  end

  assign spi_data_o = rd_state ? rd_q : {{(DATA_WIDTH-1){1'b0}}, err_q};
  assign wbm_adr_o  = addr_q;
  assign wbm_dat_o  = dat_q;
  assign wbm_we_o   = we_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign busy_o     = cyc_q;
  assign error_o    = err_q;

endmodule
